// File: rtl/cpu_types_pkg.sv
// Shared CPU / memory-system types.
// ramstate_t: RAM handshake state; arb_state_t: RAM bus arbiter FSM.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [0:0] {
    IDLE,
    OWN
  } arb_state_t;

endpackage

// File: rtl/ram_bus_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of req at or above ptr,
// wrapping to bit 0. Ports: req, ptr in; any, idx out.
module rr_pick
  import cpu_types_pkg::*;
#(
  parameter  int CPUS = 2,
  localparam int CPUW = $clog2(CPUS)
) (
  input  logic [CPUS-1:0] req,
  input  logic [CPUW-1:0] ptr,
  output logic            any,
  output logic [CPUW-1:0] idx
);

  logic            hi_any;
  logic [CPUW-1:0] hi_idx;
  logic [CPUW-1:0] lo_idx;

  // Descending scan so the lowest matching index wins in each half.
  always_comb begin
    any    = 1'b0;
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if (req[k]) begin
        any    = 1'b1;
        lo_idx = CPUW'(k);
        if (k >= int'(ptr)) begin
          hi_any = 1'b1;
          hi_idx = CPUW'(k);
        end
      end
    end
    idx = hi_any ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Round-robin RAM bus arbiter between per-CPU I and D caches.
// In: CLK, nRST, dreq, ireq, done. Out: gnt_valid, gnt_cpu, gnt_isdata, timeout_err.
module ram_bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter  int CPUS    = 2,
  parameter  int ILIMIT  = 4,
  parameter  int TIMEOUT = 16,
  localparam int CPUW    = $clog2(CPUS)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] dreq,
  input  logic [CPUS-1:0] ireq,
  input  logic            done,
  output logic            gnt_valid,
  output logic [CPUW-1:0] gnt_cpu,
  output logic            gnt_isdata,
  output logic            timeout_err
);

  localparam int OW = $clog2(TIMEOUT);
  localparam int SW = $clog2(ILIMIT + 1);

  arb_state_t      state_q, state_d;
  logic            gv_q, gv_d;
  logic [CPUW-1:0] gc_q, gc_d;
  logic            gd_q, gd_d;
  logic            te_q, te_d;
  logic [CPUW-1:0] dptr_q, dptr_d;
  logic [CPUW-1:0] iptr_q, iptr_d;
  logic [SW-1:0]   dstk_q, dstk_d;
  logic [OW-1:0]   own_q, own_d;

  logic            d_any, i_any;
  logic [CPUW-1:0] d_idx, i_idx;
  logic            pick_i;
  logic            held;
  logic            rel;
  logic            adv;

  rr_pick #(.CPUS(CPUS)) u_dpick (
    .req (dreq),
    .ptr (dptr_q),
    .any (d_any),
    .idx (d_idx)
  );

  rr_pick #(.CPUS(CPUS)) u_ipick (
    .req (ireq),
    .ptr (iptr_q),
    .any (i_any),
    .idx (i_idx)
  );

  function automatic logic [CPUW-1:0] nxt(
    input logic [CPUW-1:0] c
  );
    return (c == CPUW'(CPUS - 1)) ? '0 : c + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    gv_d    = gv_q;
    gc_d    = gc_q;
    gd_d    = gd_q;
    te_d    = 1'b0;
    dptr_d  = dptr_q;
    iptr_d  = iptr_q;
    dstk_d  = dstk_q;
    own_d   = own_q;
    rel     = 1'b0;
    adv     = 1'b0;
    pick_i  = (i_any && dstk_q == SW'(ILIMIT)) || !d_any;
    held    = gd_q ? dreq[gc_q] : ireq[gc_q];

    unique case (state_q)
      IDLE: begin
        if (!i_any) dstk_d = '0;
        if (d_any || i_any) begin
          state_d = OWN;
          gv_d    = 1'b1;
          gc_d    = pick_i ? i_idx : d_idx;
          gd_d    = !pick_i;
          own_d   = '0;
        end
      end
      OWN: begin
        if (done) begin
          rel = 1'b1;
          adv = 1'b1;
          if (!gd_q) begin
            dstk_d = '0;
          end else if (dstk_q != SW'(ILIMIT)) begin
            dstk_d = dstk_q + 1'b1;
          end
        end else if (!held) begin
          rel = 1'b1;
        end else if (own_q == OW'(TIMEOUT - 1)) begin
          rel  = 1'b1;
          adv  = 1'b1;
          te_d = 1'b1;
        end else begin
          own_d = own_q + 1'b1;
        end
      end
    endcase

    if (rel) begin
      state_d = IDLE;
      gv_d    = 1'b0;
    end
    if (adv) begin
      if (gd_q) dptr_d = nxt(gc_q);
      else      iptr_d = nxt(gc_q);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      gv_q    <= 1'b0;
      gc_q    <= '0;
      gd_q    <= 1'b0;
      te_q    <= 1'b0;
      dptr_q  <= '0;
      iptr_q  <= '0;
      dstk_q  <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      gv_q    <= gv_d;
      gc_q    <= gc_d;
      gd_q    <= gd_d;
      te_q    <= te_d;
      dptr_q  <= dptr_d;
      iptr_q  <= iptr_d;
      dstk_q  <= dstk_d;
      own_q   <= own_d;
    end
  end

  assign gnt_valid   = gv_q;
  assign gnt_cpu     = gc_q;
  assign gnt_isdata  = gd_q;
  assign timeout_err = te_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter (CPUS=3, ILIMIT=4, TIMEOUT=8).
// Table vectors, hand sequences, then random traffic against a model.
module tb_ram_bus_arbiter;

  localparam int CPUS    = 3;
  localparam int ILIMIT  = 4;
  localparam int TIMEOUT = 8;
  localparam int CPUW    = 2;

  logic            CLK  = 1'b0;
  logic            nRST = 1'b0;
  logic [CPUS-1:0] dreq = '0;
  logic [CPUS-1:0] ireq = '0;
  logic            done = 1'b0;
  logic            gnt_valid;
  logic [CPUW-1:0] gnt_cpu;
  logic            gnt_isdata;
  logic            timeout_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  ram_bus_arbiter #(
    .CPUS    (CPUS),
    .ILIMIT  (ILIMIT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .dreq        (dreq),
    .ireq        (ireq),
    .done        (done),
    .gnt_valid   (gnt_valid),
    .gnt_cpu     (gnt_cpu),
    .gnt_isdata  (gnt_isdata),
    .timeout_err (timeout_err)
  );

  typedef struct packed {
    logic [2:0] d;
    logic [2:0] i;
    logic       dn;
    logic       v;
    logic [1:0] c;
    logic       isd;
    logic       t;
  } vec_t;

  vec_t tbl [25];

  // behavioural model state
  bit m_own;
  int m_cpu;
  bit m_isd;
  bit m_terr;
  int m_age;
  int m_dptr;
  int m_iptr;
  int m_streak;

  function automatic vec_t mk(logic [2:0] d, logic [2:0] i, logic dn,
                              logic v, logic [1:0] c, logic isd, logic t);
    vec_t r;
    r = '{d: d, i: i, dn: dn, v: v, c: c, isd: isd, t: t};
    return r;
  endfunction

  // cpu / side only matter while a grant is valid
  function automatic int enc(logic v, int c, logic isd, logic t);
    if (!v) return int'(t);
    return 16 + c * 4 + int'(isd) * 2 + int'(t);
  endfunction

  function automatic int obs();
    return enc(gnt_valid, int'(gnt_cpu), gnt_isdata, timeout_err);
  endfunction

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic int scan(logic [CPUS-1:0] v, int p);
    logic [CPUS-1:0] t;
    for (int k = 0; k < CPUS; k++) begin
      t = v >> ((p + k) % CPUS);
      if (t[0]) return (p + k) % CPUS;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_own = 0; m_cpu = 0; m_isd = 0; m_terr = 0;
    m_age = 0; m_dptr = 0; m_iptr = 0; m_streak = 0;
  endtask

  task automatic model_step(logic [CPUS-1:0] dr, logic [CPUS-1:0] ir, logic dn);
    logic [CPUS-1:0] t;
    bit use_i;
    bit adv;
    adv    = 0;
    m_terr = 0;
    if (!m_own) begin
      if (ir == 0) m_streak = 0;
      if ((dr | ir) != 0) begin
        use_i = (ir != 0 && m_streak == ILIMIT) || dr == 0;
        m_isd = !use_i;
        m_cpu = use_i ? scan(ir, m_iptr) : scan(dr, m_dptr);
        m_own = 1;
        m_age = 0;
      end
    end else begin
      t = (m_isd ? dr : ir) >> m_cpu;
      if (dn) begin
        m_own = 0;
        adv   = 1;
        if (m_isd) m_streak = (m_streak + 1 > ILIMIT) ? ILIMIT : m_streak + 1;
        else       m_streak = 0;
      end else if (!t[0]) begin
        m_own = 0;
      end else if (m_age == TIMEOUT - 1) begin
        m_own  = 0;
        m_terr = 1;
        adv    = 1;
      end else begin
        m_age++;
      end
      if (adv) begin
        if (m_isd) m_dptr = (m_cpu + 1) % CPUS;
        else       m_iptr = (m_cpu + 1) % CPUS;
      end
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    dreq = '0;
    ireq = '0;
    done = 1'b0;
    step();
    nRST = 1'b1;
    model_reset();
  endtask

  task automatic wait_grant();
    int k;
    k = 0;
    while (!gnt_valid && k < 20) begin
      step();
      k++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_c [6];
    bit exp_d [6];
    int hi;
    logic [CPUS-1:0] nd, ni, msk;
    logic ndn;

    tbl[0]  = mk(3'b010, 3'b000, 0, 1, 1, 1, 0);
    tbl[1]  = mk(3'b010, 3'b000, 0, 1, 1, 1, 0);
    tbl[2]  = mk(3'b010, 3'b000, 0, 1, 1, 1, 0);
    tbl[3]  = mk(3'b010, 3'b000, 1, 0, 0, 0, 0);
    tbl[4]  = mk(3'b000, 3'b000, 0, 0, 0, 0, 0);
    tbl[5]  = mk(3'b011, 3'b000, 0, 1, 0, 1, 0);
    tbl[6]  = mk(3'b011, 3'b000, 0, 1, 0, 1, 0);
    tbl[7]  = mk(3'b011, 3'b000, 1, 0, 0, 0, 0);
    tbl[8]  = mk(3'b011, 3'b000, 0, 1, 1, 1, 0);
    tbl[9]  = mk(3'b011, 3'b000, 0, 1, 1, 1, 0);
    tbl[10] = mk(3'b011, 3'b000, 1, 0, 0, 0, 0);
    tbl[11] = mk(3'b011, 3'b000, 0, 1, 0, 1, 0);
    tbl[12] = mk(3'b011, 3'b000, 1, 0, 0, 0, 0);
    tbl[13] = mk(3'b000, 3'b000, 1, 0, 0, 0, 0);
    tbl[14] = mk(3'b100, 3'b000, 1, 1, 2, 1, 0);
    tbl[15] = mk(3'b100, 3'b000, 0, 1, 2, 1, 0);
    tbl[16] = mk(3'b000, 3'b000, 0, 0, 0, 0, 0);
    tbl[17] = mk(3'b011, 3'b000, 0, 1, 1, 1, 0);
    tbl[18] = mk(3'b011, 3'b000, 1, 0, 0, 0, 0);
    tbl[19] = mk(3'b000, 3'b100, 0, 1, 2, 0, 0);
    tbl[20] = mk(3'b000, 3'b100, 1, 0, 0, 0, 0);
    tbl[21] = mk(3'b000, 3'b011, 0, 1, 0, 0, 0);
    tbl[22] = mk(3'b000, 3'b011, 1, 0, 0, 0, 0);
    tbl[23] = mk(3'b010, 3'b010, 0, 1, 1, 1, 0);
    tbl[24] = mk(3'b010, 3'b010, 1, 0, 0, 0, 0);

    // reset held with every request high
    nRST = 1'b0;
    dreq = '1;
    ireq = '1;
    repeat (3) step();
    chk("rst_out", int'({gnt_valid, gnt_cpu, gnt_isdata, timeout_err}), 0);
    nRST = 1'b1;
    step();
    chk("rst_first", obs(), enc(1, 0, 1, 0));

    do_reset();
    for (int n = 0; n < 25; n++) begin
      dreq = tbl[n].d;
      ireq = tbl[n].i;
      done = tbl[n].dn;
      step();
      chk($sformatf("tbl%0d", n), obs(),
          enc(tbl[n].v, int'(tbl[n].c), tbl[n].isd, tbl[n].t));
    end

    // starvation limit
    exp_c = '{0, 0, 0, 0, 1, 0};
    exp_d = '{1, 1, 1, 1, 0, 1};
    do_reset();
    dreq = 3'b001;
    ireq = 3'b010;
    for (int g = 0; g < 6; g++) begin
      wait_grant();
      chk($sformatf("starve_gnt%0d", g), obs(), enc(1, exp_c[g], exp_d[g], 0));
      done = 1'b1;
      step();
      done = 1'b0;
      chk($sformatf("starve_rel%0d", g), int'(gnt_valid), 0);
    end

    // watchdog
    do_reset();
    dreq = 3'b011;
    step();
    chk("wd_gnt", obs(), enc(1, 0, 1, 0));
    hi = 0;
    while (gnt_valid && hi < 40) begin
      hi++;
      step();
    end
    chk("wd_len", hi, TIMEOUT);
    chk("wd_terr", obs(), enc(0, 0, 0, 1));
    step();
    chk("wd_next", obs(), enc(1, 1, 1, 0));

    // asynchronous reset while owning the bus
    #2;
    nRST = 1'b0;
    #1;
    chk("async_rst", int'({gnt_valid, gnt_cpu, gnt_isdata, timeout_err}), 0);
    @(negedge CLK);

    // random traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nd  = (dreq | (3'($urandom) & 3'($urandom)));
      ni  = (ireq | (3'($urandom) & 3'($urandom)));
      if ($urandom % 16 == 0) nd = nd & ~3'($urandom);
      if ($urandom % 16 == 0) ni = ni & ~3'($urandom);
      ndn = m_own ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
      if (ndn && m_own && $urandom % 2 == 0) begin
        msk = 3'(1) << m_cpu;
        if (m_isd) nd = nd & ~msk;
        else       ni = ni & ~msk;
      end
      dreq = nd;
      ireq = ni;
      done = ndn;
      model_step(nd, ni, ndn);
      step();
      chk($sformatf("rnd%0d", cyc), obs(), enc(m_own, m_cpu, m_isd, m_terr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Registered round-robin arbiter that shares the single RAM port between the per-CPU instruction and data caches. It sits in front of the memory controller and decides which CPU, and which cache side (I or D), owns the RAM bus. It holds that grant until the controller reports completion, a timeout fires, or the owner withdraws. Data traffic has priority over instruction traffic, with an anti-starvation limit and a watchdog.

## Interface
Parameters:
- CPUS, 2: number of CPUs (≥2).
- ILIMIT, 4: consecutive completed data grants allowed while any ireq is pending.
- TIMEOUT, 16: maximum cycles a grant may stay in OWN without `done` (≥2).

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- dreq  in  CPUS  per-CPU data request (dREN|dWEN); held until served.
- ireq  in  CPUS  per-CPU instruction fetch request; held until served.
- done  in  1  controller pulse: final RAM word of the current transaction reached ACCESS.
- gnt_valid  out  1  a grant is active.
- gnt_cpu  out  CPUW  granted CPU index; CPUW = $clog2(CPUS).
- gnt_isdata  out  1  1 = data side granted, 0 = instruction side.
- timeout_err  out  1  one-cycle pulse when a grant is force-released.

## Operation
- State machine with two states, IDLE and OWN. All outputs are registered.
- IDLE:
  - If any dreq or ireq is set, select a winner, register gnt_cpu and gnt_isdata, set gnt_valid, clear owncnt, and go to OWN.
  - Otherwise stay in IDLE with gnt_valid=0.
- Selection:
  - If any ireq is set and dstreak==ILIMIT, choose an instruction winner.
  - Else, if any dreq is set, choose a data winner.
  - Else, choose an instruction winner.
  - Data winner: first set bit of dreq scanning upward from dptr, with wrap. Instruction winner: same scan of ireq from iptr.
- OWN, evaluated in priority order:
  - done=1: release. Advance the pointer of the granted side to gnt_cpu+1 (mod CPUS).
    - Data completion increments dstreak, saturating at ILIMIT.
    - Instruction completion clears dstreak.
  - Granted request bit is low and done=0: abort release. Pointers and dstreak are unchanged.
  - owncnt==TIMEOUT-1: forced release. Pulse timeout_err, advance the pointer as for done, leave dstreak unchanged.
  - Otherwise: increment owncnt and stay in OWN.
- Every release returns to IDLE with gnt_valid=0. There is always a one-cycle dead cycle between grants.
- dstreak also clears in IDLE whenever no ireq is pending.
- `done` is ignored in IDLE.

## Timing
- Reset values: gnt_valid=0, gnt_cpu=0, gnt_isdata=0, timeout_err=0, dptr=0, iptr=0, dstreak=0, owncnt=0, state=IDLE.
- Grant latency: a request sampled in IDLE at edge t shows gnt_valid=1 after edge t. Outputs are stable for the whole OWN period.
- done sampled at edge t gives gnt_valid=0 after edge t. The next grant appears earliest after edge t+1.
- done and a request drop in the same cycle: treated as done (pointer advances).
- Timeout: with no done, gnt_valid stays high for exactly TIMEOUT cycles. timeout_err is high for the first IDLE cycle after release.
- Simultaneous dreq and ireq from the same CPU: data wins unless the ILIMIT rule applies.
- Asynchronous nRST mid-OWN: grant drops immediately and all state returns to reset values.
- Width rules:
  - Pointers are CPUW bits with modulo-CPUS wrap; CPUS−1 wraps to 0, including non-power-of-2 CPUS.
  - owncnt is $clog2(TIMEOUT) bits.
  - dstreak is $clog2(ILIMIT+1) bits.

## Structure
- Add `arb_state_t` (IDLE, OWN) to cpu_types_pkg, next to ramstate_t.
- One sub-module, `rr_pick`: combinational round-robin finder.
  - Inputs: req[CPUS], ptr.
  - Outputs: any, idx.
  - Instantiated twice, once for data and once for instruction.
- The memory controller consumes gnt_cpu and gnt_isdata in place of its internal cpuid selection.

## Test plan
- Reset: hold nRST=0 with all requests high → every output 0. Release → first grant is cpu0 data.
- Single request: dreq=2'b10 at cycle 0 → cycle 1 gnt_valid=1, gnt_cpu=1, gnt_isdata=1. done at cycle 4 → gnt_valid=0 at cycle 5.
- Fairness: dreq=2'b11 held, done 2 cycles after each grant → grant sequence cpu0, cpu1, cpu0, cpu1 with one dead cycle between grants.
- Starvation limit: dreq[0] held, ireq[1] held, ILIMIT=4 → four data grants to cpu0, then an instruction grant to cpu1 (gnt_isdata=0), then data resumes.
- Watchdog: TIMEOUT=8, dreq=2'b11, done never asserted → cpu0 gnt_valid high for 8 cycles, a timeout_err pulse, then a grant to cpu1.
- Abort and reset: dreq[0] dropped at cycle 3 of OWN → IDLE next cycle and dptr unchanged. Separately, nRST pulsed mid-OWN → outputs 0 asynchronously.
